// File: rtl/mdu_pkg.sv
// MDU opcode encodings, FSM state type and op-class decoders shared by the MDU.
// MDU_MADD_EN widens the mult class to the madd/maddu/msub/msubu accumulate ops.
package mdu_pkg;

  localparam logic [3:0] OP_NONE  = 4'd0;
  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MFHI  = 4'd5;
  localparam logic [3:0] OP_MFLO  = 4'd6;
  localparam logic [3:0] OP_MTHI  = 4'd7;
  localparam logic [3:0] OP_MTLO  = 4'd8;
  localparam logic [3:0] OP_MADD  = 4'd9;
  localparam logic [3:0] OP_MADDU = 4'd10;
  localparam logic [3:0] OP_MSUB  = 4'd11;
  localparam logic [3:0] OP_MSUBU = 4'd12;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } mdu_state_e;

  function automatic logic is_md_op(input logic [3:0] op);
    logic r;
    r = (op >= OP_MULT) && (op <= OP_DIVU);
`ifdef MDU_MADD_EN
    r = r || ((op >= OP_MADD) && (op <= OP_MSUBU));
`endif
    return r;
  endfunction

  function automatic logic is_div_op(input logic [3:0] op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

endpackage

// File: rtl/mdu.sv
// Multi-cycle multiply/divide unit holding HI/LO; busy covers the whole operation.
// Optional accumulate ops (madd/maddu/msub/msubu) are built when MDU_MADD_EN is defined.
module mdu
  import mdu_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic [3:0]  MDUOp,
  input  logic        start,
  input  logic        req,
  output logic        busy,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic [31:0] MDUOut
);

  localparam int CW = $clog2((MULT_CYCLES > DIV_CYCLES ? MULT_CYCLES : DIV_CYCLES) + 1);

  mdu_state_e    state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          accept, finish;
  logic [3:0]    op_q;
  logic [31:0]   a_q, b_q;
  logic [31:0]   hi, lo;
  logic [63:0]   res;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    accept    = 1'b0;
    finish    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start && !req && is_md_op(MDUOp)) begin
          accept    = 1'b1;
          state_nxt = ST_RUN;
          cnt_nxt   = is_div_op(MDUOp) ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
        end
      end
      ST_RUN: begin
        cnt_nxt = cnt - CW'(1);
        if (cnt == CW'(1)) begin
          finish    = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Datapath works only on the captured operands, so A/B may change during RUN.
  logic [63:0] a_sx, b_sx, a_zx, b_zx, prod_s, prod_u;
  logic [31:0] div_b, q_s_raw, r_s_raw, q_s, r_s, q_u, r_u;
  logic        div_ovf, div_zero;

  assign a_sx   = {{32{a_q[31]}}, a_q};
  assign b_sx   = {{32{b_q[31]}}, b_q};
  assign a_zx   = {32'd0, a_q};
  assign b_zx   = {32'd0, b_q};
  assign prod_s = a_sx * b_sx;
  assign prod_u = a_zx * b_zx;

  // Divisor is forced to 1 on div-by-zero/overflow so the raw dividers stay well defined.
  assign div_zero = (b_q == 32'd0);
  assign div_ovf  = (a_q == 32'h8000_0000) && (b_q == 32'hFFFF_FFFF);
  assign div_b    = (div_zero || div_ovf) ? 32'd1 : b_q;
  assign q_s_raw  = $signed(a_q) / $signed(div_b);
  assign r_s_raw  = $signed(a_q) % $signed(div_b);
  assign q_s      = div_ovf ? 32'h8000_0000 : q_s_raw;
  assign r_s      = div_ovf ? 32'd0 : r_s_raw;
  assign q_u      = a_q / div_b;
  assign r_u      = a_q % div_b;

  always_comb begin
    res = {hi, lo};
    case (op_q)
      OP_MULT:  res = prod_s;
      OP_MULTU: res = prod_u;
      OP_DIV:   if (!div_zero) res = {r_s, q_s};
      OP_DIVU:  if (!div_zero) res = {r_u, q_u};
`ifdef MDU_MADD_EN
      OP_MADD:  res = {hi, lo} + prod_s;
      OP_MADDU: res = {hi, lo} + prod_u;
      OP_MSUB:  res = {hi, lo} - prod_s;
      OP_MSUBU: res = {hi, lo} - prod_u;
`endif
      default:  res = {hi, lo};
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      hi   <= '0;
      lo   <= '0;
      op_q <= OP_NONE;
      a_q  <= '0;
      b_q  <= '0;
    end else begin
      if (accept) begin
        op_q <= MDUOp;
        a_q  <= A;
        b_q  <= B;
      end
      if (finish) begin
        {hi, lo} <= res;
      end else if (state == ST_IDLE && !req) begin
        if (MDUOp == OP_MTHI) hi <= A;
        if (MDUOp == OP_MTLO) lo <= A;
      end
    end
  end

  assign busy = (state == ST_RUN);
  assign HI   = hi;
  assign LO   = lo;

  always_comb begin
    MDUOut = 32'd0;
    if (MDUOp == OP_MFHI) MDUOut = hi;
    else if (MDUOp == OP_MFLO) MDUOut = lo;
  end

endmodule

// File: tb/tb_mdu.sv
// Scoreboarded bench for mdu: directed cases followed by randomized ops against an arithmetic model.
module tb_mdu;
  import mdu_pkg::*;

  localparam int MC = 5;
  localparam int DC = 10;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] A = '0, B = '0;
  logic [3:0]  MDUOp = '0;
  logic        start = 1'b0, req = 1'b0;
  logic        busy;
  logic [31:0] HI, LO, MDUOut;

  mdu #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk(clk), .reset(reset), .A(A), .B(B), .MDUOp(MDUOp), .start(start), .req(req),
    .busy(busy), .HI(HI), .LO(LO), .MDUOut(MDUOut)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          cycles;
    string       name;
  } exp_t;

  exp_t        sb[$];
  int          n_tests = 0;
  int          n_fail = 0;
  logic [31:0] m_hi = '0, m_lo = '0;
  int          run_cycles = 0;
  logic        prev_busy = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic bit is_md(input logic [3:0] op);
    bit r;
    r = (op >= 4'd1 && op <= 4'd4);
`ifdef MDU_MADD_EN
    r = r || (op >= 4'd9 && op <= 4'd12);
`endif
    return r;
  endfunction

  // Architectural result of one op on {HI,LO}, from plain integer arithmetic.
  function automatic logic [63:0] model(input logic [3:0] op, input logic [31:0] a,
                                        input logic [31:0] b, input logic [63:0] hilo);
    longint      sa, sbv, sq, sr, sp;
    logic [63:0] pu;
    sa  = longint'($signed(a));
    sbv = longint'($signed(b));
    sp  = sa * sbv;
    pu  = {32'd0, a} * {32'd0, b};
    case (op)
      4'd1: return sp;
      4'd2: return pu;
      4'd3: begin
        if (b == 32'd0) return hilo;
        sq = sa / sbv;
        sr = sa % sbv;
        return {sr[31:0], sq[31:0]};
      end
      4'd4: begin
        if (b == 32'd0) return hilo;
        return {a % b, a / b};
      end
      4'd9:  return hilo + sp;
      4'd10: return hilo + pu;
      4'd11: return hilo - sp;
      4'd12: return hilo - pu;
      default: return hilo;
    endcase
  endfunction

  // Monitor: each busy falling edge is one completion, matched against the queue head.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (!reset) begin
        run_cycles = 0;
        prev_busy  = 1'b0;
      end else begin
        if (busy) begin
          run_cycles++;
        end else if (prev_busy) begin
          if (sb.size() == 0) begin
            check("unexpected_completion", 32'd1, 32'd0);
          end else begin
            e = sb.pop_front();
            check({e.name, "_hi"}, HI, e.hi);
            check({e.name, "_lo"}, LO, e.lo);
            check({e.name, "_busy_cycles"}, 32'(run_cycles), 32'(e.cycles));
          end
          run_cycles = 0;
        end
        prev_busy = busy;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input string name, input logic [3:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic r);
    exp_t        e;
    logic [63:0] nv;
    MDUOp = op; A = a; B = b; start = 1'b1; req = r;
    if (!r && !busy && is_md(op)) begin
      nv       = model(op, a, b, {m_hi, m_lo});
      e.hi     = nv[63:32];
      e.lo     = nv[31:0];
      e.cycles = (op == 4'd3 || op == 4'd4) ? DC : MC;
      e.name   = name;
      sb.push_back(e);
      m_hi     = nv[63:32];
      m_lo     = nv[31:0];
    end
    tick();
    start = 1'b0; req = 1'b0; MDUOp = 4'd0;
    A = $urandom; B = $urandom;
  endtask

  task automatic wait_idle(input string name);
    int k;
    k = 0;
    @(negedge clk);
    while (busy === 1'b1 && k < 40) begin
      @(negedge clk);
      k++;
    end
    if (k >= 40) check({name, "_timeout"}, 32'(busy), 32'd0);
    tick();
  endtask

  task automatic mt(input logic [3:0] op, input logic [31:0] a, input logic r);
    MDUOp = op; A = a; req = r;
    if (!r && !busy) begin
      if (op == 4'd7) m_hi = a;
      if (op == 4'd8) m_lo = a;
    end
    tick();
    MDUOp = 4'd0; req = 1'b0;
  endtask

  task automatic read_check(input string name);
    MDUOp = 4'd5; #1;
    check({name, "_mfhi"}, MDUOut, m_hi);
    MDUOp = 4'd6; #1;
    check({name, "_mflo"}, MDUOut, m_lo);
    MDUOp = 4'd0; #1;
    check({name, "_mdu_out_idle"}, MDUOut, 32'd0);
  endtask

  initial begin : timeout_guard
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin : stim
    int ops[$];
    logic [3:0]  op;
    logic [31:0] a, b;
    logic        r;

    repeat (2) tick();
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_hi", HI, 32'd0);
    check("reset_lo", LO, 32'd0);
    reset = 1'b1;
    tick();

    issue("mult_neg", 4'd1, 32'hFFFF_FFFE, 32'd3, 1'b0);
    wait_idle("mult_neg");
    check("mult_neg_hi_lit", HI, 32'hFFFF_FFFF);
    check("mult_neg_lo_lit", LO, 32'hFFFF_FFFA);

    issue("multu_max", 4'd2, 32'hFFFF_FFFF, 32'd2, 1'b0);
    wait_idle("multu_max");
    check("multu_hi_lit", HI, 32'h0000_0001);
    check("multu_lo_lit", LO, 32'hFFFF_FFFE);

    issue("div_neg", 4'd3, 32'hFFFF_FFF9, 32'd2, 1'b0);
    wait_idle("div_neg");
    check("div_neg_lo_lit", LO, 32'hFFFF_FFFD);
    check("div_neg_hi_lit", HI, 32'hFFFF_FFFF);

    mt(4'd7, 32'h11, 1'b0);
    mt(4'd8, 32'h22, 1'b0);
    issue("divu_zero", 4'd4, 32'd7, 32'd0, 1'b0);
    wait_idle("divu_zero");
    check("divu_zero_hi_lit", HI, 32'h11);
    check("divu_zero_lo_lit", LO, 32'h22);

    issue("mult_req", 4'd1, 32'd9, 32'd9, 1'b1);
    check("req_blocks_busy", 32'(busy), 32'd0);
    check("req_hi_kept", HI, m_hi);
    check("req_lo_kept", LO, m_lo);

    issue("mfhi_start", 4'd5, 32'd1, 32'd1, 1'b0);
    check("non_md_start_busy", 32'(busy), 32'd0);

    issue("div_req_mid", 4'd3, 32'd100, 32'hFFFF_FFF9, 1'b0);
    tick();
    mt(4'd7, 32'hCAFE_F00D, 1'b1);
    wait_idle("div_req_mid");

    issue("mult_busy_mthi", 4'd1, 32'd7, 32'd6, 1'b0);
    mt(4'd7, 32'hDEAD_BEEF, 1'b0);
    mt(4'd8, 32'hDEAD_BEEF, 1'b0);
    wait_idle("mult_busy_mthi");

    mt(4'd7, 32'hDEAD_BEEF, 1'b0);
    read_check("mthi_idle");
    check("mthi_idle_lit", HI, 32'hDEAD_BEEF);

    issue("div_ovf", 4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    wait_idle("div_ovf");
    check("div_ovf_lo_lit", LO, 32'h8000_0000);
    check("div_ovf_hi_lit", HI, 32'd0);

`ifdef MDU_MADD_EN
    mt(4'd7, 32'd0, 1'b0);
    mt(4'd8, 32'hFFFF_FFFF, 1'b0);
    issue("maddu_carry", 4'd10, 32'd1, 32'd1, 1'b0);
    wait_idle("maddu_carry");
    check("maddu_hi_lit", HI, 32'd1);
    check("maddu_lo_lit", LO, 32'd0);
`endif

    issue("div_reset", 4'd3, 32'd1000, 32'd3, 1'b0);
    tick();
    sb.delete();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    m_hi = '0;
    m_lo = '0;
    check("mid_reset_busy", 32'(busy), 32'd0);
    check("mid_reset_hi", HI, 32'd0);
    check("mid_reset_lo", LO, 32'd0);

    ops = '{4, 3, 2, 1};
`ifdef MDU_MADD_EN
    ops.push_back(9); ops.push_back(10); ops.push_back(11); ops.push_back(12);
`endif
    for (int i = 0; i < 40; i++) begin
      r = ($urandom_range(0, 7) == 0);
      a = $urandom;
      case ($urandom_range(0, 3))
        0: b = 32'd0;
        1: b = 32'($urandom_range(1, 20));
        2: b = 32'hFFFF_FFFF;
        default: b = $urandom;
      endcase
      if ($urandom_range(0, 4) == 0) begin
        mt($urandom_range(0, 1) ? 4'd7 : 4'd8, a, r);
      end else begin
        op = 4'(ops[$urandom_range(0, ops.size() - 1)]);
        issue("rand_op", op, a, b, r);
        if (!r) wait_idle("rand_op");
        else check("rand_req_busy", 32'(busy), 32'd0);
      end
      read_check("rand");
    end

    repeat (3) tick();
    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
